// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the word arbiter and its requesters/word transmitter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                err;
  logic                busy;
  logic [GW-1:0]       grant_id;
  logic                tx_start;
  logic [31:0]         tx_data;
  logic                tx_done;

  modport master (
    input  req, req_data, tx_done,
    output ack, err, busy, grant_id, tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, err, busy, grant_id, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit word UART transmitter between N_REQ
// requesters, with a watchdog that aborts a send that never completes.
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              div_clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus,
  output logic [1:0]        dbg_state_o
);
  localparam int GW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = (TIMEOUT_CYC > 0) ? WDW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [WDW-1:0] WD_SAT   = '1;
  localparam logic [GW-1:0]  LAST_RST = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [WDW-1:0]     wdog_q, wdog_d;

  logic [GW-1:0]      win;
  logic               win_vld;
  logic               wd_hit;

  // First set request after the last winner, wrapping modulo N_REQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_vld && bus.req[(int'(last_q) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win     = GW'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  assign wd_hit = (TIMEOUT_CYC != 0) && (wdog_q == WD_LIMIT);

  // Handshakes: req is a level held until its one-cycle ack; tx_start is a level
  // held until the transmitter's one-cycle tx_done (or a watchdog abort).
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    ack_d      = '0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_id_d = win;
          last_d     = win;
          tx_data_d  = bus.req_data[32*int'(win) +: 32];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          wdog_d     = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (bus.tx_done || wd_hit) begin
          tx_start_d        = 1'b0;
          ack_d[grant_id_q] = 1'b1;
          err_d             = !bus.tx_done;
          state_d           = ACK;
        end else if (wdog_q != WD_SAT) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign dbg_state_o  = state_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 32-bit word UART transmitter (and its single `tx` line) between several requesters: CPU-ready reply, PC report, and future status words. It sits in the CPU communication path between the command FSM and the word transmitter. It grants the transmitter round-robin, latches the granted word, holds the start level until the transmitter reports done, and returns a one-cycle ack to the winner. A watchdog aborts a send that never completes.

## Interface
- `N_REQ`, default 3: number of requesters; legal range 2..8.
- `TIMEOUT_CYC`, default 4096: maximum `div_clk` cycles in SEND before abort; 0 disables the watchdog.
- `GW`, derived as max(1, $clog2(N_REQ)); not user-set.
- `div_clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `div_clk`.
- `req` in N_REQ: level request per requester; held until its ack.
- `req_data` in 32*N_REQ: word for requester i at bits [32i+31:32i].
- `ack` out N_REQ: one-cycle pulse to the requester whose word finished or was aborted.
- `err` out 1: one-cycle pulse, coincident with `ack`, when the send was aborted by the watchdog.
- `busy` out 1: high in SEND and ACK.
- `grant_id` out GW: index of the current or last granted requester.
- `tx_start` out 1: start level to the word transmitter.
- `tx_data` out 32: word to the transmitter.
- `tx_done` in 1: one-cycle completion pulse from the word transmitter.

## Operation
- Reset values: `tx_start`=0, `tx_data`=0, `ack`=0, `err`=0, `busy`=0, `grant_id`=0.
- The internal pointer `last` resets to N_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- State machine:
  - IDLE: if any `req` bit is high, pick the first set bit searching `last+1`, `last+2`, … with wrap modulo N_REQ. Then `grant_id`←winner, `last`←winner, `tx_data`←winner's word, `tx_start`←1, watchdog←0, go to SEND. If no `req` bit is high, stay in IDLE.
  - SEND: hold `tx_start`=1 and hold `tx_data` stable. Requester `req`/`req_data` changes are ignored.
    - On `tx_done`: `tx_start`←0, `ack[grant_id]`←1, go to ACK.
    - Otherwise, if `TIMEOUT_CYC`≠0 and watchdog == TIMEOUT_CYC-1: do the same, plus `err`←1.
    - Otherwise the watchdog increments.
  - ACK: `ack` and `err` return to 0, go to IDLE. `tx_start` is low here, which guarantees at least a 2-cycle low gap between words.
- A requester that drops `req` mid-send still receives its `ack`. Its transfer is never cancelled.
- `tx_done` seen in IDLE or ACK is ignored.
- Watchdog width is $clog2(TIMEOUT_CYC+1). It saturates and does not wrap.

## Timing
- Grant latency: `req` sampled high at edge t (in IDLE) → `tx_start`=1 and `tx_data` valid after edge t, i.e. SEND starting cycle t+1.
- Completion: `tx_done` sampled at edge d (in SEND) → `ack` high for exactly the cycle after edge d; IDLE after edge d+1. The next grant is possible at edge d+2, so `tx_start` is low for at least 2 cycles.
- Abort: `ack`+`err` appear TIMEOUT_CYC cycles after `tx_start` rose.
- `tx_done` and the watchdog limit in the same cycle: `tx_done` wins, `err` stays 0.
- Simultaneous requests are served one at a time in rotating order. Each requester waits at most N_REQ-1 other transfers.
- Reset mid-SEND: all outputs and `last` return to reset values on that edge with no `ack` issued. The word transmitter shares the same reset.

## Test plan
- Single request: `req`=001, data 0x00000003; transmitter model asserts `tx_done` 40 cycles after `tx_start` → `tx_data`=0x00000003, `tx_start` high 40 cycles, `ack`=001 for 1 cycle, `busy` low 2 cycles later.
- Round-robin: `req`=111 held, data 0xA/0xB/0xC → grants in order 0,1,2,0; each `ack` matches its `grant_id`; `tx_start` low ≥2 cycles between words.
- Fairness after wrap: grant 1, then `req`=101 → next grant 2, then 0.
- Data latch: change `req_data` of the granted requester to 0xDEADBEEF mid-SEND → `tx_data` unchanged until ACK.
- Watchdog: TIMEOUT_CYC=16, `tx_done` never asserted → `ack`+`err` exactly 16 cycles after `tx_start` rose. Then `tx_done` on cycle 15 → `err`=0.
- Reset mid-SEND: assert `reset` 10 cycles into SEND → next cycle all outputs 0, no `ack`; a fresh `req`=010 after release is granted to requester 0-priority order (requester 1 is served).
